// File: rtl/fifo_read_packetizer.sv
// fifo_read_packetizer: async-FIFO read port to a framed valid/ready stream.
// Define FIFO_RD_FWFT_EN when the FIFO is first-word-fall-through.
module fifo_read_packetizer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  run;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] buf1;
  logic [15:0]           idx;
  logic                  hs;
  logic                  cap;
  logic                  infl;
  logic [1:0]            occ;

  assign m_valid = (count != 2'd0);
  assign m_last  = m_valid && (idx == LAST_IDX);
  assign hs      = m_valid && m_ready;
  assign occ     = count + {1'b0, infl} - {1'b0, hs};
  assign r_en    = run && !empty && (occ < 2'd2);

`ifdef FIFO_RD_FWFT_EN
  assign infl = 1'b0;
  assign cap  = r_en;
`else
  logic inflight;

  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) inflight <= 1'b0;
    else         inflight <= r_en;

  assign infl = inflight;
  assign cap  = inflight;
`endif

  // m_data is the head entry, buf1 the tail
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run    <= 1'b0;
      count  <= 2'd0;
      m_data <= '0;
      buf1   <= '0;
    end else begin
      run <= 1'b1;
      unique case (1'b1)
        cap && !hs: begin
          if (count == 2'd0) m_data <= fifo_data;
          else               buf1   <= fifo_data;
          count <= count + 2'd1;
        end
        hs && !cap: begin
          m_data <= buf1;
          count  <= count - 2'd1;
        end
        cap && hs: begin
          if (count == 2'd1) begin
            m_data <= fifo_data;
          end else begin
            m_data <= buf1;
            buf1   <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      idx      <= 16'd0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (hs) begin
      word_cnt <= word_cnt + CNT_ONE;
      if (m_last) begin
        idx     <= 16'd0;
        pkt_cnt <= pkt_cnt + CNT_ONE;
      end else begin
        idx <= idx + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_packetizer.sv
// tb_fifo_read_packetizer: directed + random stream checks against a queue model.
// Honours FIFO_RD_FWFT_EN for the FIFO model and first-word latency.
module tb_fifo_read_packetizer;

  localparam int PKT = 4;
`ifdef FIFO_RD_FWFT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        rclk;
  logic        rrst_n;
  logic        r_en;
  logic [7:0]  fifo_data;
  logic        empty;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] word_cnt;
  logic [15:0] pkt_cnt;

  logic        w_en;
  logic        w_r_en;
  logic [7:0]  w_fdata;
  logic [7:0]  w_src;
  logic [7:0]  w_m_data;
  logic        w_valid;
  logic        w_last;
  logic [3:0]  w_word;
  logic [3:0]  w_pkt;

  fifo_read_packetizer #(
    .DATA_WIDTH(8), .PKT_LEN(PKT), .CNT_WIDTH(16)
  ) u_dut (
    .rclk(rclk), .rrst_n(rrst_n), .r_en(r_en),
    .fifo_data(fifo_data), .empty(empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .word_cnt(word_cnt), .pkt_cnt(pkt_cnt)
  );

  fifo_read_packetizer #(
    .DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(4)
  ) u_wrap (
    .rclk(rclk), .rrst_n(rrst_n), .r_en(w_r_en),
    .fifo_data(w_fdata), .empty(!w_en),
    .m_data(w_m_data), .m_valid(w_valid), .m_ready(w_en),
    .m_last(w_last), .word_cnt(w_word), .pkt_cnt(w_pkt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO model: array plus push/pop counts
  logic [7:0] mem [1024];
  int n_push = 0;
  int n_pop = 0;
  int underflow = 0;

  assign empty = (n_push == n_pop);

  always @(posedge rclk) begin
    if (r_en) begin
      if (n_pop == n_push) begin
        underflow <= underflow + 1;
      end else begin
        n_pop <= n_pop + 1;
`ifndef FIFO_RD_FWFT_EN
        fifo_data <= mem[n_pop % 1024];
`endif
      end
    end
  end

`ifdef FIFO_RD_FWFT_EN
  assign fifo_data = mem[n_pop % 1024];
  assign w_fdata = w_src;
`else
  always @(posedge rclk or negedge rrst_n)
    if (!rrst_n)     w_fdata <= 8'd0;
    else if (w_r_en) w_fdata <= w_src;
`endif

  always @(posedge rclk or negedge rrst_n)
    if (!rrst_n)     w_src <= 8'd0;
    else if (w_r_en) w_src <= w_src + 8'd1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int acc = 0;
  int drained = 0;
  int npulse = 0;
  logic stall = 1'b0;
  logic [7:0] stall_d = 8'd0;
  logic [7:0] dummy;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[n_push % 1024] = w;
    n_push++;
    exp_q.push_back(w);
  endtask

  task automatic step(input logic rdy, output logic hs);
    @(negedge rclk);
    m_ready = rdy;
    #1;
    chk("pop_while_empty", 32'(r_en && empty), 0);
    if (stall) begin
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_data", 32'(m_data), 32'(stall_d));
    end
    chk("last", 32'(m_last), 32'(m_valid && (acc % PKT == PKT - 1)));
    hs = m_valid && m_ready;
    if (hs) begin
      chk("have_word", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("data", 32'(m_data), 32'(exp_q[0]));
        dummy = exp_q.pop_front();
        drained++;
      end
      acc++;
    end
    stall = m_valid && !m_ready;
    stall_d = m_data;
    if (r_en) npulse++;
    @(posedge rclk);
    #1;
    chk("word_cnt", 32'(word_cnt), 32'(acc % 65536));
    chk("pkt_cnt", 32'(pkt_cnt), 32'((acc / PKT) % 65536));
  endtask

  logic hs_o;
  int nhs;
  int lost;
  int n2;

  initial begin
    rrst_n = 1'b0;
    m_ready = 1'b0;
    w_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    repeat (3) @(negedge rclk);
    #1;
    chk("rst_r_en", 32'(r_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    rrst_n = 1'b1;
    #1;
    chk("edge0_r_en", 32'(r_en), 0);
    @(posedge rclk); #1;
    chk("edge1_r_en", 32'(r_en), 1);
    chk("edge1_valid", 32'(m_valid), 0);
    @(posedge rclk); #1;
    chk("edge2_valid", 32'(m_valid), 32'(LAT == 1));
    @(posedge rclk); #1;
    chk("edge3_valid", 32'(m_valid), 1);

    nhs = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, hs_o);
      if (hs_o) nhs++;
    end
    chk("stream_back_to_back", 32'(nhs), 8);
    chk("stream_pkt_cnt", 32'(pkt_cnt), 2);

    for (int i = 0; i < 5; i++) push(8'($urandom));
    npulse = 0;
    repeat (10) step(1'b0, hs_o);
    chk("bp_pulses", 32'(npulse), 2);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_head", 32'(m_data), 32'(exp_q[0]));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b1, hs_o);
    chk("bp_delivered", 32'(exp_q.size()), 0);
    chk("bp_word_cnt", 32'(word_cnt), 13);

    for (int i = 0; i < 3; i++) push(8'($urandom));
    npulse = 0;
    repeat (8) step(1'b1, hs_o);
    chk("drain_word_cnt", 32'(word_cnt), 16);
    chk("drain_pulses", 32'(npulse), 3);
    chk("drain_valid", 32'(m_valid), 0);
    chk("drain_underflow", 32'(underflow), 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && exp_q.size() < 10)
        push(8'($urandom));
      step($urandom_range(0, 3) != 0, hs_o);
    end
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b1, hs_o);
    chk("rand_delivered", 32'(exp_q.size()), 0);

    for (int i = 0; i < 6; i++) push(8'($urandom));
    repeat (4) step(1'b0, hs_o);
    chk("pre_rst_valid", 32'(m_valid), 1);
    @(negedge rclk);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_r_en", 32'(r_en), 0);
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_data", 32'(m_data), 0);
    chk("mid_rst_last", 32'(m_last), 0);
    chk("mid_rst_word_cnt", 32'(word_cnt), 0);
    chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 0);
    acc = 0;
    stall = 1'b0;
    lost = n_pop - drained;
    chk("mid_rst_lost", 32'(lost), 2);
    for (int i = 0; i < lost && exp_q.size() > 0; i++) begin
      dummy = exp_q.pop_front();
      drained++;
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(1'b1, hs_o);
    chk("resume_delivered", 32'(exp_q.size()), 0);
    chk("resume_pkt_cnt", 32'(pkt_cnt), 1);
    chk("final_underflow", 32'(underflow), 0);

    w_en = 1'b1;
    n2 = 0;
    for (int c = 0; c < 60 && n2 < 17; c++) begin
      @(negedge rclk);
      #1;
      if (w_valid && w_en) begin
        chk("wrap_data", 32'(w_m_data), 32'(n2 % 256));
        chk("wrap_last", 32'(w_last), 1);
        n2++;
        if (n2 == 17) begin
          @(posedge rclk);
          #1;
          w_en = 1'b0;
        end
      end
    end
    @(negedge rclk);
    #1;
    chk("wrap_words", 32'(n2), 17);
    chk("wrap_word_cnt", 32'(w_word), 1);
    chk("wrap_pkt_cnt", 32'(w_pkt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
